// File: rtl/rom_scan_if.sv
// Bus bundle between a scan requester and rom_scan_reader, including the
// ROM address/data pair so the reader and its ROM share one connection.
//
//   slave  : rom_scan_reader side (takes requests, drives the ROM address)
//   master : requester/ROM side
//
// Optional checksum port exists only when ROM_SCAN_CKSUM_EN is defined.
interface rom_scan_if #(
    parameter int AW = 10,
    parameter int DW = 5
);
    logic          start;
    logic          dir;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          busy;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          done;
`ifdef ROM_SCAN_CKSUM_EN
    logic [15:0]   checksum;
`endif

    modport slave (
`ifdef ROM_SCAN_CKSUM_EN
        output checksum,
`endif
        input  start, dir, base_addr, len, rom_data,
        output rom_addr, busy, data_out, data_valid, done
    );

    modport master (
`ifdef ROM_SCAN_CKSUM_EN
        input  checksum,
`endif
        output start, dir, base_addr, len, rom_data,
        input  rom_addr, busy, data_out, data_valid, done
    );
endinterface

// File: rtl/rom_scan_reader.sv
// rom_scan_reader: on a start pulse, walks a block of ROM addresses up or
// down, one address per cycle, and realigns the synchronous ROM read data
// with a valid strobe. Signals done one cycle after the last valid word.
//
// Ports
//   clk    : rising-edge clock, shared with the ROM
//   rst_n  : asynchronous active-low reset
//   bus    : rom_scan_if.slave (start/dir/base_addr/len request, rom_addr/
//            rom_data ROM pair, busy/data_out/data_valid/done results)
//
// Build option: define ROM_SCAN_CKSUM_EN to add a 16-bit running sum of the
// delivered words on bus.checksum.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; rom_addr holds last issued address
// RUN   | one address issued per cycle until the count is exhausted
// DRAIN | waiting for the ROM read pipeline to empty
// FIN   | done pulse; start ignored; back to IDLE next cycle
module rom_scan_reader #(
    parameter int AW      = 10,
    parameter int DW      = 5,
    parameter int ROM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    rom_scan_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    localparam logic [AW:0]   LEN_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   REM_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t         state_q;
    logic           dir_q;
    logic [AW-1:0]  addr_q;
    logic [AW:0]    remain_q;
    logic [ROM_LAT:0] issue_q;   // bit 0: address on bus this cycle
    logic [DW-1:0]  data_q;
    logic           valid_q;
    logic           done_q;
    logic           busy_q;

    logic [AW:0]    len_clamped;
    logic [AW-1:0]  addr_next;

    assign len_clamped = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
    // Wraps naturally modulo 2**AW.
    assign addr_next   = dir_q ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dir_q    <= 1'b0;
            addr_q   <= '0;
            remain_q <= '0;
            issue_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // Stage 0 defaults to idle; the FSM overrides it when issuing.
            issue_q <= {issue_q[ROM_LAT-1:0], 1'b0};
            valid_q <= issue_q[ROM_LAT];
            if (issue_q[ROM_LAT]) begin
                data_q <= bus.rom_data;
            end
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        dir_q  <= bus.dir;
                        busy_q <= 1'b1;
                        if (len_clamped == '0) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_RUN;
                            addr_q     <= bus.base_addr;
                            issue_q[0] <= 1'b1;
                            remain_q   <= len_clamped;
                        end
                    end
                end
                S_RUN: begin
                    remain_q <= remain_q - REM_ONE;
                    if (remain_q == REM_ONE) begin
                        state_q <= S_DRAIN;
                    end else begin
                        addr_q     <= addr_next;
                        issue_q[0] <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Empty pipeline coincides with the last valid word.
                    if (issue_q == '0) begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_addr   = addr_q;
    assign bus.busy       = busy_q;
    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.done       = done_q;

`ifdef ROM_SCAN_CKSUM_EN
    logic [15:0] cksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum_q <= '0;
        end else if (state_q == S_IDLE && bus.start) begin
            cksum_q <= '0;
        end else if (valid_q) begin
            cksum_q <= cksum_q + {{(16-DW){1'b0}}, data_q};
        end
    end

    assign bus.checksum = cksum_q;
`endif
endmodule
